// File: rtl/router_pkt_src_pkg.sv
// rtl/router_pkt_src_pkg.sv - shared widths, constants and FSM state type for router_pkt_src
package router_pkt_src_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int BYTE_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HDR,
        S_PAY,
        S_PAR,
        S_GAP
    } state_t;

    // Router header layout: length in the upper bits, destination port in the lower two.
    function automatic logic [BYTE_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_src_if.sv
// rtl/router_pkt_src_if.sv - command, payload and router-side pins of router_pkt_src (ROUTER_PKT_SRC_PARITY_INJ_EN adds inj_err)
interface router_pkt_src_if;
    import router_pkt_src_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              pay_valid;
    logic              pay_ready;
    logic [BYTE_W-1:0] pay_data;
    logic              busy;
    logic              pkt_valid;
    logic [BYTE_W-1:0] pkt_data;
    logic              cmd_err;
    logic              pkt_done;
`ifdef ROUTER_PKT_SRC_PARITY_INJ_EN
    logic              inj_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy, inj_err,
        output cmd_ready, pay_ready, pkt_valid, pkt_data, cmd_err, pkt_done
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy, inj_err,
        input  cmd_ready, pay_ready, pkt_valid, pkt_data, cmd_err, pkt_done
    );
`else
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
        output cmd_ready, pay_ready, pkt_valid, pkt_data, cmd_err, pkt_done
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
        input  cmd_ready, pay_ready, pkt_valid, pkt_data, cmd_err, pkt_done
    );
`endif

endinterface

// File: rtl/router_pkt_src_fifo.sv
// rtl/router_pkt_src_fifo.sv - synchronous byte FIFO (pkt_src_fifo) holding one packet payload
module pkt_src_fifo #(
    parameter int DEPTH = 63,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST_I    = DEPTH - 1;
    localparam int DEPTH_I   = DEPTH;
    localparam logic [PTR_W-1:0] LAST_PTR  = LAST_I[PTR_W-1:0];
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_DEPTH = DEPTH_I[CNT_W-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth need not be a power of two, so pointers wrap explicitly.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_src.sv
// rtl/router_pkt_src.sv - buffers a command's payload and serialises header/payload/parity into the router input; ROUTER_PKT_SRC_PARITY_INJ_EN enables parity corruption via inj_err
module router_pkt_src
    import router_pkt_src_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    router_pkt_src_if.master bus
);

    localparam int FIFO_CNT_W = $clog2(MAX_LEN + 1);
    localparam int GAP_LAST_I = GAP_CYCLES - 1;
    localparam logic [LEN_W:0]        MAX_LEN_EXT = MAX_LEN[LEN_W:0];
    localparam logic [7:0]            GAP_LAST    = GAP_LAST_I[7:0];
    localparam logic [LEN_W-1:0]      LEN_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [FIFO_CNT_W-1:0] FIFO_ONE    = {{(FIFO_CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [BYTE_W-1:0]   parity_q;
    logic [7:0]          gap_q;
    logic                cmd_err_q;
    logic                pkt_done_q;

    logic                cmd_ready_c;
    logic                pay_ready_c;
    logic                cmd_fire;
    logic                cmd_legal;
    logic                pay_fire;
    logic                fill_done;
    logic                pkt_valid_c;
    logic [BYTE_W-1:0]   pkt_data_c;
    logic [BYTE_W-1:0]   header;
    logic [BYTE_W-1:0]   tx_parity;

    logic                fifo_pop;
    logic [BYTE_W-1:0]   fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    // cmd_ready is masked by reset so it stays low until the cycle after reset drops.
    assign cmd_ready_c = (state_q == S_IDLE) && !reset;
    assign pay_ready_c = (state_q == S_FILL) && (cnt_q != len_q) && !fifo_full;
    assign cmd_fire    = bus.cmd_valid && cmd_ready_c;
    assign pay_fire    = bus.pay_valid && pay_ready_c;
    assign cmd_legal   = (bus.cmd_addr != ADDR_INVALID) && (bus.cmd_len != '0)
                         && ({1'b0, bus.cmd_len} <= MAX_LEN_EXT);
    // Counting the byte accepted this edge lets the header follow the last byte directly.
    assign fill_done   = (cnt_q == len_q) || (pay_fire && (cnt_q + LEN_ONE == len_q));
    assign header      = make_header(len_q, addr_q);

`ifdef ROUTER_PKT_SRC_PARITY_INJ_EN
    logic inj_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (cmd_fire && cmd_legal) begin
            inj_q <= bus.inj_err;
        end
    end

    assign tx_parity = inj_q ? (parity_q ^ {BYTE_W{1'b1}}) : parity_q;
`else
    assign tx_parity = parity_q;
`endif

    pkt_src_fifo #(
        .DEPTH (MAX_LEN),
        .WIDTH (BYTE_W),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pay_fire),
        .push_data (bus.pay_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        pkt_valid_c = 1'b0;
        pkt_data_c  = '0;
        fifo_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire && cmd_legal) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_done && !bus.busy) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                pkt_valid_c = 1'b1;
                pkt_data_c  = header;
                if (!bus.busy) begin
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                pkt_valid_c = 1'b1;
                pkt_data_c  = fifo_head;
                if (!bus.busy && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_count == FIFO_ONE) begin
                        state_d = S_PAR;
                    end
                end
            end
            S_PAR: begin
                pkt_data_c = tx_parity;
                if (!bus.busy) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            parity_q   <= '0;
            gap_q      <= '0;
            cmd_err_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_err_q  <= cmd_fire && !cmd_legal;
            pkt_done_q <= (state_q == S_PAR) && !bus.busy;
            if (cmd_fire && cmd_legal) begin
                addr_q   <= bus.cmd_addr;
                len_q    <= bus.cmd_len;
                cnt_q    <= '0;
                parity_q <= '0;
            end
            if (pay_fire) begin
                cnt_q    <= cnt_q + LEN_ONE;
                parity_q <= parity_q ^ bus.pay_data;
            end
            if ((state_q == S_HDR) && !bus.busy) begin
                parity_q <= parity_q ^ header;
            end
            if (state_q == S_PAR) begin
                gap_q <= '0;
            end else if (state_q == S_GAP) begin
                gap_q <= gap_q + 8'd1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.pay_ready = pay_ready_c;
    assign bus.pkt_valid = pkt_valid_c;
    assign bus.pkt_data  = pkt_data_c;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.pkt_done  = pkt_done_q;

endmodule

// File: doc/router_pkt_src.md
# router_pkt_src

Packet source that sits directly upstream of the 1x3 router input port. It accepts a destination command and its payload bytes, buffers the whole payload, then serialises a complete packet (header, payload, parity) onto the router's `pkt_valid`/`data_in` pins, stalling on the router's `busy`. It exists so every upstream client meets the router's input protocol by construction.

## Interface
- `MAX_LEN`, 63: largest payload length accepted; also the buffer depth. The header length field is 6 bits, so 63 is the ceiling.
- `GAP_CYCLES`, 2: idle cycles forced between the parity byte and the next header.

- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_addr`  in  2  destination port 0..2.
- `cmd_len`  in  6  payload length 1..MAX_LEN.
- `pay_valid`  in  1  payload byte offered.
- `pay_ready`  out  1  payload byte accepted when `pay_valid & pay_ready`.
- `pay_data`  in  8  payload byte.
- `busy`  in  1  router input stall.
- `pkt_valid`  out  1  drives router `pkt_valid`.
- `pkt_data`  out  8  drives router `data_in`.
- `cmd_err`  out  1  one-cycle pulse: command rejected.
- `pkt_done`  out  1  one-cycle pulse: parity byte consumed.

## Operation
- **IDLE**
  - `cmd_ready=1`.
  - A command with `cmd_addr==3`, or with `cmd_len==0` or `cmd_len>MAX_LEN`, is consumed and pulses `cmd_err` the next cycle. The state stays IDLE.
  - A legal command latches addr and len, clears the parity register and the byte counter, and moves to FILL.
- **FILL**
  - `pay_ready=1` until `cnt==len`.
  - Each accepted byte is written to the FIFO and XORed into parity.
  - When `cnt==len` and `busy==0`, move to HDR.
- **HDR**
  - `pkt_valid=1`, `pkt_data={len,addr}`; the header is XORed into parity.
  - The byte is consumed on an edge where `busy==0`, then move to PAY.
- **PAY**
  - `pkt_valid=1`, `pkt_data` = FIFO head.
  - The FIFO pops on each edge with `busy==0`.
  - After the last pop, move to PAR.
- **PAR**
  - `pkt_valid=0`, `pkt_data` = parity.
  - The byte is held until an edge with `busy==0`.
  - On that edge pulse `pkt_done` and move to GAP.
- **GAP**
  - Outputs idle for GAP_CYCLES.
  - Then move to IDLE.
- Parity is the XOR of the header and all payload bytes.
- `pkt_data` and `pkt_valid` change only after a consuming edge; while `busy==1` they are held stable.
- `cmd_ready=0` and `pay_ready=0` in every state except those listed above. Payload bytes offered in IDLE are not accepted.
- Reset mid-packet:
  - Return to IDLE immediately.
  - Flush the FIFO.
  - Drop `pkt_valid` the next cycle. No parity byte is sent.

## Timing
- Reset values: `cmd_ready=0`, `pay_ready=0`, `pkt_valid=0`, `pkt_data=8'h00`, `cmd_err=0`, `pkt_done=0`. `cmd_ready` rises on the first cycle after reset deasserts.
- Command acceptance to first `pay_ready`: 1 cycle.
- Last payload byte accepted to header on the bus: 1 cycle, or later if `busy` is high.
- With `busy` low throughout, the bus activity for length N is:
  - N+1 cycles with `pkt_valid=1` (header plus payload);
  - then 1 parity cycle;
  - then GAP_CYCLES idle cycles.
- `cmd_err` rises 1 cycle after the rejected handshake.
- `pkt_done` rises 1 cycle after the parity-consuming edge.
- `busy` asserting in the same cycle a byte appears stalls that byte. No byte is ever skipped or duplicated.

## Configuration
- Macro `ROUTER_PKT_SRC_PARITY_INJ_EN`.
- **Defined**
  - Adds input `inj_err` (1 bit), sampled at command acceptance.
  - When set, the transmitted parity is the true parity XOR `8'hFF`. This exercises the router's `error` output.
- **Undefined**
  - The port is absent.
  - Parity is always correct.

## Structure
- Shared package holds:
  - `ADDR_W=2`, `LEN_W=6`, `BYTE_W=8`;
  - the invalid-address constant `2'd3`;
  - the state enum (IDLE, FILL, HDR, PAY, PAR, GAP).
- One sub-module, `pkt_src_fifo`: synchronous byte FIFO, depth MAX_LEN, with push/pop, count, full and empty.

## Test plan
- **Length 9 to port 0, `busy` low.** Header `8'h24` on the bus, 9 payload bytes in order, then parity equal to the XOR of all 10 bytes with `pkt_valid=0`. `pkt_done` follows 1 cycle later.
- **Length 14 to port 1, `busy` forced high for 3 cycles on payload byte 5.** Byte 5 is held for 3 cycles, with no skip or duplicate. Header is `8'h39`.
- **Length 16 to port 2, `busy` high during PAR for 2 cycles.** Parity is held; `pkt_done` fires once, after `busy` falls.
- **Command with addr 3, then a command with len 0.** `cmd_err` pulses twice, `pkt_valid` never rises, and the state stays IDLE.
- **Reset asserted during PAY of a length-20 packet.** `pkt_valid=0` the next cycle, the FIFO is empty, and a following length-1 packet is sent correctly.
- **With `ROUTER_PKT_SRC_PARITY_INJ_EN` defined and `inj_err=1`, length 9.** Transmitted parity equals the true parity XOR `8'hFF`.
